wishbone_reg_slave: RTL and testbench
=====================================

// Module: wishbone_reg_slave
// PURPOSE
//  8-bit Wishbone classic responder exposing the PMIC control/status register bank.
//  Answers single read/write cycles from an on-chip Wishbone initiator: drives rail-enable outputs and
//  samples asynchronous status inputs into live and sticky-event registers. Raises a maskable interrupt.
// PARAMETERS
//  ID_VALUE     8'hA5  constant returned by the ID register
//  CTRL_RESET   8'h00  reset value of CTRL, and therefore of o_ctrl
//  SYNC_STAGES  2      flop stages on i_status; legal range 2..4
// PORTS
//  i_clk        in   1  system clock; all logic on posedge
//  i_rst_n      in   1  asynchronous, active-low reset
//  i_wb_cyc     in   1  Wishbone cycle valid
//  i_wb_stb     in   1  Wishbone strobe (chip select)
//  i_wb_we      in   1  1 = write, 0 = read
//  i_wb_adr     in   8  register address
//  i_wb_dat     in   8  write data
//  o_wb_dat     out  8  read data; valid only while o_wb_ack=1, else 8'h00
//  o_wb_ack     out  1  transfer acknowledge, one-cycle pulse
//  o_wb_err     out  1  error acknowledge (WBS_ERR_EN only; tied 0 otherwise)
//  i_status     in   8  asynchronous PMIC status bits (power-good, fault, ...)
//  o_ctrl       out  8  registered rail-enable/control bits (= CTRL)
//  o_irq        out  1  registered |(EVENT & IRQ_MASK)
//  o_state      out  2  debug view of the FSM state
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - o_wb_ack=0, o_wb_err=0, o_wb_dat=0, o_irq=0, o_state=IDLE.
//   - CTRL=CTRL_RESET; EVENT, IRQ_MASK, SCRATCH, WCOUNT=0; sync chain=0.
//   - Reset mid-cycle abandons the access. No ack is issued and no register is written.
//  FSM states: IDLE(0), ACK(1), HOLD(2); encoding 3 is unused and recovers to IDLE.
//   - IDLE: on cyc&stb, latch adr/we/dat and perform the access (write commits this edge) -> ACK.
//   - ACK: o_wb_ack=1 (or o_wb_err) for exactly one cycle, read data on o_wb_dat -> HOLD.
//   - HOLD: stay while cyc&stb still high (no second access). Go to IDLE when stb=0.
//   - Latency: request seen at edge N -> ack high during cycle N+1. Minimum 3 cycles per transfer.
//   - Read data is captured at the IDLE->ACK edge; the read has no side effects.
//  Register map (unlisted addresses are unmapped)
//   - 0x00 ID        RO   ID_VALUE
//   - 0x01 CTRL      RW   drives o_ctrl
//   - 0x02 STATUS    RO   synchronised i_status (last stage)
//   - 0x03 EVENT     W1C  sticky; bit set on rising edge of a synchronised status bit
//   - 0x04 IRQ_MASK  RW   1 = event bit enabled onto o_irq
//   - 0x05 SCRATCH   RW   no function
//   - 0x06 WCOUNT    RO   count of accepted writes to mapped RW/W1C registers; 8-bit, wraps 0xFF->0x00
//  Boundaries
//   - Simultaneous EVENT set and W1C on the same bit: set wins.
//   - Writes to RO addresses: acked, ignored, WCOUNT unchanged.
//   - Unmapped read returns 8'h00.
//   - stb without cyc is ignored.
//   - o_irq lags the EVENT/MASK update by one cycle.
// CONFIGURATION
//  WBS_ERR_EN defined
//   - Unmapped address: o_wb_err pulses instead of o_wb_ack (same timing); o_wb_dat=0.
//   - Writes to RO addresses also error.
//  WBS_ERR_EN undefined
//   - Every access acks; o_wb_err is constant 0.
// STRUCTURE
//  Package wbs_pkg: register address localparams (ADR_ID..ADR_WCOUNT), FSM state encodings.
//  Sub-module status_sync: parameterised SYNC_STAGES x 8 synchroniser plus rising-edge detect.
//   - Outputs: level[7:0], rise[7:0].
//  Top: FSM, register bank, read mux, irq flop.
// TESTING
//  1. Reset release -> read 0x00 returns 8'hA5.
//     Read 0x01 returns CTRL_RESET; o_irq=0; o_state=0.
//  2. Write 0x01=8'h3C -> ack exactly 1 cycle after stb; o_ctrl=8'h3C.
//     Read 0x01 returns 8'h3C; WCOUNT=1.
//  3. Drive i_status 0x00->0x81, wait SYNC_STAGES+1 -> STATUS=0x81, EVENT=0x81.
//     Then IRQ_MASK=0x01 -> o_irq=1. Write EVENT=0x01 -> EVENT=0x80, o_irq=0.
//  4. Write EVENT=0x02 in the same cycle a bit-1 rising edge arrives -> EVENT bit1 stays 1.
//  5. Hold stb high 5 cycles after ack -> one ack only; register written once; WCOUNT +1.
//     Assert i_rst_n=0 during ACK -> ack drops immediately.
//  6. Read 0x7F -> ack with data 0x00 (no macro); err pulse and no ack (WBS_ERR_EN).
//     256 writes to SCRATCH -> WCOUNT wraps to its start value.

Source files
------------

// File: rtl/wbs_pkg.sv
// rtl/wbs_pkg.sv - register map addresses and FSM state encodings for the Wishbone register slave
package wbs_pkg;

  localparam logic [7:0] ADR_ID       = 8'h00;
  localparam logic [7:0] ADR_CTRL     = 8'h01;
  localparam logic [7:0] ADR_STATUS   = 8'h02;
  localparam logic [7:0] ADR_EVENT    = 8'h03;
  localparam logic [7:0] ADR_IRQ_MASK = 8'h04;
  localparam logic [7:0] ADR_SCRATCH  = 8'h05;
  localparam logic [7:0] ADR_WCOUNT   = 8'h06;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/status_sync.sv
// rtl/status_sync.sv - multi-stage synchroniser for the 8 asynchronous status bits with rising-edge detect
module status_sync #(
  parameter int STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] status,
  output logic [7:0] level,
  output logic [7:0] rise
);

  logic [STAGES-1:0][7:0] chain_q;
  logic [7:0]             prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], status};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign level = chain_q[STAGES-1];
  assign rise  = chain_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/wishbone_reg_slave.sv
// rtl/wishbone_reg_slave.sv - 8-bit Wishbone classic PMIC control/status register slave
// Optional WBS_ERR_EN: unmapped accesses and writes to read-only registers return o_wb_err instead of o_wb_ack.
module wishbone_reg_slave
  import wbs_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter logic [7:0] CTRL_RESET  = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_we,
  input  logic [7:0] i_wb_adr,
  input  logic [7:0] i_wb_dat,
  output logic [7:0] o_wb_dat,
  output logic       o_wb_ack,
  output logic       o_wb_err,
  input  logic [7:0] i_status,
  output logic [7:0] o_ctrl,
  output logic       o_irq,
  output logic [1:0] o_state
);

  state_t     state_q, state_d;
  logic [7:0] ctrl_q, event_q, mask_q, scratch_q, wcount_q, rdata_q;
  logic [7:0] status_level, status_rise;
  logic [7:0] rd_mux, w1c;
  logic       irq_q, access, bad, wr_ok, count_en;

  status_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .status  (i_status),
    .level   (status_level),
    .rise    (status_rise)
  );

  assign access = (state_q == ST_IDLE) && i_wb_cyc && i_wb_stb;

`ifdef WBS_ERR_EN
  logic err_q;
  assign bad = (i_wb_adr > ADR_WCOUNT) ||
               (i_wb_we && (i_wb_adr == ADR_ID || i_wb_adr == ADR_STATUS || i_wb_adr == ADR_WCOUNT));
`else
  assign bad = 1'b0;
`endif

  assign wr_ok = access && i_wb_we && !bad;

  always_comb begin
    rd_mux   = 8'h00;
    w1c      = 8'h00;
    count_en = 1'b0;
    case (i_wb_adr)
      ADR_ID:       rd_mux = ID_VALUE;
      ADR_CTRL:     rd_mux = ctrl_q;
      ADR_STATUS:   rd_mux = status_level;
      ADR_EVENT:    rd_mux = event_q;
      ADR_IRQ_MASK: rd_mux = mask_q;
      ADR_SCRATCH:  rd_mux = scratch_q;
      ADR_WCOUNT:   rd_mux = wcount_q;
      default:      rd_mux = 8'h00;
    endcase
    if (wr_ok) begin
      count_en = (i_wb_adr == ADR_CTRL) || (i_wb_adr == ADR_EVENT) ||
                 (i_wb_adr == ADR_IRQ_MASK) || (i_wb_adr == ADR_SCRATCH);
      if (i_wb_adr == ADR_EVENT) w1c = i_wb_dat;
    end
  end

  // A rising edge arriving on the same cycle as a W1C keeps the bit set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q    <= CTRL_RESET;
      event_q   <= '0;
      mask_q    <= '0;
      scratch_q <= '0;
      wcount_q  <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_q   <= |(event_q & mask_q);
      event_q <= (event_q & ~w1c) | status_rise;
      if (access) rdata_q <= (i_wb_we || bad) ? 8'h00 : rd_mux;
      if (wr_ok) begin
        case (i_wb_adr)
          ADR_CTRL:     ctrl_q    <= i_wb_dat;
          ADR_IRQ_MASK: mask_q    <= i_wb_dat;
          ADR_SCRATCH:  scratch_q <= i_wb_dat;
          default:      ;
        endcase
      end
      if (count_en) wcount_q <= wcount_q + 8'd1;
    end
  end

`ifdef WBS_ERR_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    err_q <= 1'b0;
    else if (access) err_q <= bad;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    o_wb_dat = 8'h00;
    o_wb_ack = 1'b0;
    o_wb_err = 1'b0;
    case (state_q)
      ST_IDLE: if (i_wb_cyc && i_wb_stb) state_d = ST_ACK;
      ST_ACK: begin
        state_d  = ST_HOLD;
        o_wb_dat = rdata_q;
`ifdef WBS_ERR_EN
        o_wb_ack = !err_q;
        o_wb_err = err_q;
`else
        o_wb_ack = 1'b1;
`endif
      end
      ST_HOLD: if (!(i_wb_cyc && i_wb_stb)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_ctrl  = ctrl_q;
  assign o_irq   = irq_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_wishbone_reg_slave.sv
// tb/tb_wishbone_reg_slave.sv - scoreboard bench for wishbone_reg_slave against a register-map model
module tb_wishbone_reg_slave;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] CTRL_RESET  = 8'h00;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [7:0] i_wb_adr = 8'h00, i_wb_dat = 8'h00, i_status = 8'h00;
  logic [7:0] o_wb_dat, o_ctrl;
  logic       o_wb_ack, o_wb_err, o_irq;
  logic [1:0] o_state;

  wishbone_reg_slave #(.ID_VALUE(8'hA5), .CTRL_RESET(CTRL_RESET), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .o_wb_err(o_wb_err), .i_status(i_status), .o_ctrl(o_ctrl), .o_irq(o_irq), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       err;
    logic       rd;
    logic [7:0] data;
    logic [7:0] adr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_ctrl, m_event, m_mask, m_scratch, m_wcount, m_status;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = CTRL_RESET; m_event = 8'h00; m_mask = 8'h00;
    m_scratch = 8'h00; m_wcount = 8'h00; m_status = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] adr);
    case (adr)
      8'h00:   return 8'hA5;
      8'h01:   return m_ctrl;
      8'h02:   return m_status;
      8'h03:   return m_event;
      8'h04:   return m_mask;
      8'h05:   return m_scratch;
      8'h06:   return m_wcount;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_err(input logic we, input logic [7:0] adr);
`ifdef WBS_ERR_EN
    return (adr > 8'h06) || (we && (adr == 8'h00 || adr == 8'h02 || adr == 8'h06));
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every response the DUT presents is matched against the oldest expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_wb_ack || o_wb_err)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_response ack=%0b err=%0b dat=0x%0h @%0t", o_wb_ack, o_wb_err, o_wb_dat, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("resp_err adr=0x%0h", e.adr), {31'd0, o_wb_err}, {31'd0, e.err});
        chk($sformatf("resp_ack adr=0x%0h", e.adr), {31'd0, o_wb_ack}, {31'd0, !e.err});
        if (e.rd) chk($sformatf("rdata adr=0x%0h", e.adr), {24'd0, o_wb_dat}, {24'd0, e.data});
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [7:0] dat, input int hold);
    exp_t e;
    int   n;
    e.err  = model_err(we, adr);
    e.rd   = !we;
    e.data = e.err ? 8'h00 : model_read(adr);
    e.adr  = adr;
    sb.push_back(e);
    if (we && !e.err) begin
      case (adr)
        8'h01: begin m_ctrl = dat; m_wcount++; end
        8'h03: begin m_event = m_event & ~dat; m_wcount++; end
        8'h04: begin m_mask = dat; m_wcount++; end
        8'h05: begin m_scratch = dat; m_wcount++; end
        default: ;
      endcase
    end
    @(posedge i_clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat;
    @(posedge i_clk); #1;
    chk("ack_latency", {31'd0, o_wb_ack | o_wb_err}, 32'd1);
    chk("state_ack", {30'd0, o_state}, 32'd1);
    n = 0;
    while (!(o_wb_ack || o_wb_err) && n < 8) begin
      @(posedge i_clk); #1; n++;
    end
    if (n == 8) chk("ack_timeout", 32'd1, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      if (i == hold - 1) chk("state_hold", {30'd0, o_state}, 32'd2);
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(posedge i_clk);
  endtask

  task automatic set_status(input logic [7:0] v);
    m_event  = m_event | (v & ~m_status);
    m_status = v;
    i_status = v;
  endtask

  task automatic chk_outputs(input string tag);
    #1;
    chk({tag, "_ctrl"}, {24'd0, o_ctrl}, {24'd0, m_ctrl});
    chk({tag, "_irq"}, {31'd0, o_irq}, {31'd0, |(m_event & m_mask)});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    int         r;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1;
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_irq", {31'd0, o_irq}, 32'd0);
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_ctrl", {24'd0, o_ctrl}, {24'd0, CTRL_RESET});
    wb_xfer(1'b0, 8'h00, 8'h00, 0);
    wb_xfer(1'b0, 8'h01, 8'h00, 0);

    // stb without cyc must be ignored
    @(posedge i_clk); #1 i_wb_stb = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 chk("stb_no_cyc_state", {30'd0, o_state}, 32'd0);
    i_wb_stb = 1'b0;

    wb_xfer(1'b1, 8'h01, 8'h3C, 0);
    chk_outputs("after_ctrl");
    wb_xfer(1'b0, 8'h01, 8'h00, 0);
    wb_xfer(1'b0, 8'h06, 8'h00, 0);

    #1 set_status(8'h81);
    repeat (SYNC_STAGES + 2) @(posedge i_clk);
    wb_xfer(1'b0, 8'h02, 8'h00, 0);
    wb_xfer(1'b0, 8'h03, 8'h00, 0);
    wb_xfer(1'b1, 8'h04, 8'h01, 0);
    chk_outputs("irq_on");
    wb_xfer(1'b1, 8'h03, 8'h01, 0);
    chk_outputs("irq_off");
    wb_xfer(1'b0, 8'h03, 8'h00, 0);

    // W1C of bit 1 lands on the same edge that its rising edge sets it
    @(posedge i_clk); #1 i_status = 8'h83;
    repeat (SYNC_STAGES - 1) @(posedge i_clk);
    wb_xfer(1'b1, 8'h03, 8'h02, 0);
    m_event  = m_event | 8'h02;
    m_status = 8'h83;
    wb_xfer(1'b0, 8'h03, 8'h00, 0);

    wb_xfer(1'b1, 8'h05, 8'h5A, 5);
    wb_xfer(1'b0, 8'h05, 8'h00, 0);
    wb_xfer(1'b0, 8'h06, 8'h00, 0);

    wb_xfer(1'b0, 8'h7F, 8'h00, 0);
    wb_xfer(1'b1, 8'h00, 8'h12, 0);
    wb_xfer(1'b0, 8'h06, 8'h00, 0);

    // reset during the ACK cycle
    #1 set_status(8'h00);
    repeat (SYNC_STAGES + 2) @(posedge i_clk);
    #1 i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 8'h05; i_wb_dat = 8'hEE;
    @(posedge i_clk); #1;
    chk("pre_reset_ack", {31'd0, o_wb_ack}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("reset_drops_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("reset_state", {30'd0, o_state}, 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    model_reset();
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    wb_xfer(1'b0, 8'h05, 8'h00, 0);
    wb_xfer(1'b0, 8'h06, 8'h00, 0);

    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        #1 set_status(8'($urandom));
        repeat (SYNC_STAGES + 2) @(posedge i_clk);
      end
      r = $urandom_range(0, 9);
      a = (r <= 7) ? 8'(r) : ((r == 8) ? 8'h7F : 8'($urandom));
      d = 8'($urandom);
      wb_xfer(1'($urandom_range(0, 1)), a, d, $urandom_range(0, 2));
      chk_outputs("rand");
    end

    wb_xfer(1'b0, 8'h06, 8'h00, 0);
    for (int k = 0; k < 256; k++) wb_xfer(1'b1, 8'h05, 8'(k), 0);
    wb_xfer(1'b0, 8'h06, 8'h00, 0);
    wb_xfer(1'b0, 8'h05, 8'h00, 0);

    repeat (4) @(posedge i_clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
